// File: rtl/div_signed_frontend_pkg.sv
// Shared encodings and constants for the signed divide front-end.
// Operation codes follow funct3[1:0] of the RISC-V M-extension divide group.
package div_signed_frontend_pkg;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_RDY,
      ST_ISSUE,
      ST_WAIT_DIV,
      ST_FIX,
      ST_DONE
   } state_e;

   localparam logic [31:0] INT_MIN  = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

   // Two's complement negate when neg is set; wraps, so INT_MIN maps to itself.
   function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] x);
      return neg ? (~x + 32'd1) : x;
   endfunction

endpackage

// File: rtl/DivUnsigned32bit.sv
// 32-bit unsigned restoring divider, one quotient bit per cycle.
// Has no reset: any power-up state drains to idle within a bounded number of cycles.
module DivUnsigned32bit (
   input  logic        clk,
   input  logic        start,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        ready,
   output logic        valid,
   output logic        error,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic        busy_reg;
   logic        valid_reg;
   logic        error_reg;
   logic [5:0]  count_reg;
   logic [31:0] quo_reg;
   logic [31:0] rem_reg;
   logic [31:0] dvs_reg;

   logic [32:0] shifted;
   logic [32:0] diff;

   // Partial remainder stays below the divisor, so 33 bits hold the shifted value.
   always_comb begin
      shifted = {rem_reg, quo_reg[31]};
      diff    = shifted - {1'b0, dvs_reg};
   end

   always_ff @(posedge clk) begin
      valid_reg <= 1'b0;
      if (busy_reg) begin
         if (!diff[32]) begin
            rem_reg <= diff[31:0];
            quo_reg <= {quo_reg[30:0], 1'b1};
         end else begin
            rem_reg <= shifted[31:0];
            quo_reg <= {quo_reg[30:0], 1'b0};
         end
         count_reg <= count_reg - 6'd1;
         if (count_reg == 6'd1) begin
            busy_reg  <= 1'b0;
            valid_reg <= 1'b1;
         end
      end else if (start) begin
         error_reg <= (divisor == '0);
         if (divisor > dividend) begin
            // Quotient is trivially zero: answer on the next cycle.
            quo_reg   <= '0;
            rem_reg   <= dividend;
            valid_reg <= 1'b1;
         end else begin
            busy_reg  <= 1'b1;
            count_reg <= 6'd32;
            quo_reg   <= dividend;
            rem_reg   <= '0;
            dvs_reg   <= divisor;
         end
      end
   end

   assign ready     = ~busy_reg;
   assign valid     = valid_reg;
   assign error     = error_reg;
   assign quotient  = quo_reg;
   assign remainder = rem_reg;

endmodule

// File: rtl/div_signed_frontend.sv
// RISC-V DIV/DIVU/REM/REMU front-end: magnitude conversion, unsigned divider
// hand-off, sign fix-up and the architectural divide-by-zero/overflow results.
module div_signed_frontend
   import div_signed_frontend_pkg::*;
#(
   parameter int FAST_SPECIAL = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic        ready,
   output logic        valid,
   output logic [31:0] result
);

   state_e      state_reg, state_next;
   div_op_e     op_reg, op_next;
   logic [31:0] rs1_reg, rs1_next;
   logic        b_zero_reg, b_zero_next;
   logic        neg_a_reg, neg_a_next;
   logic        neg_b_reg, neg_b_next;
   logic [31:0] mag_a_reg, mag_a_next;
   logic [31:0] mag_b_reg, mag_b_next;
   logic [31:0] quo_reg, quo_next;
   logic [31:0] rem_reg, rem_next;
   logic [31:0] result_reg, result_next;

   logic        in_signed;
   logic        in_neg_a;
   logic        in_neg_b;

   logic        div_start;
   logic        div_ready;
   logic        div_valid;
   logic        div_error_unused;
   logic [31:0] div_quo;
   logic [31:0] div_rem;

   assign in_signed = ~op[0];
   assign in_neg_a  = in_signed & rs1[31];
   assign in_neg_b  = in_signed & rs2[31];

   DivUnsigned32bit u_divu (
      .clk       (clk),
      .start     (div_start),
      .dividend  (mag_a_reg),
      .divisor   (mag_b_reg),
      .ready     (div_ready),
      .valid     (div_valid),
      .error     (div_error_unused),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= ST_IDLE;
         op_reg     <= OP_DIV;
         rs1_reg    <= '0;
         b_zero_reg <= 1'b0;
         neg_a_reg  <= 1'b0;
         neg_b_reg  <= 1'b0;
         mag_a_reg  <= '0;
         mag_b_reg  <= '0;
         quo_reg    <= '0;
         rem_reg    <= '0;
         result_reg <= '0;
      end else begin
         state_reg  <= state_next;
         op_reg     <= op_next;
         rs1_reg    <= rs1_next;
         b_zero_reg <= b_zero_next;
         neg_a_reg  <= neg_a_next;
         neg_b_reg  <= neg_b_next;
         mag_a_reg  <= mag_a_next;
         mag_b_reg  <= mag_b_next;
         quo_reg    <= quo_next;
         rem_reg    <= rem_next;
         result_reg <= result_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      op_next     = op_reg;
      rs1_next    = rs1_reg;
      b_zero_next = b_zero_reg;
      neg_a_next  = neg_a_reg;
      neg_b_next  = neg_b_reg;
      mag_a_next  = mag_a_reg;
      mag_b_next  = mag_b_reg;
      quo_next    = quo_reg;
      rem_next    = rem_reg;
      result_next = result_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               op_next     = div_op_e'(op);
               rs1_next    = rs1;
               b_zero_next = (rs2 == '0);
               neg_a_next  = in_neg_a;
               neg_b_next  = in_neg_b;
               mag_a_next  = neg_if(in_neg_a, rs1);
               mag_b_next  = neg_if(in_neg_b, rs2);
               if (FAST_SPECIAL != 0 && rs2 == '0) begin
                  result_next = op[1] ? rs1 : ALL_ONES;
                  state_next  = ST_DONE;
               end else if (FAST_SPECIAL != 0 && in_signed && rs1 == INT_MIN && rs2 == ALL_ONES) begin
                  result_next = op[1] ? '0 : INT_MIN;
                  state_next  = ST_DONE;
               end else begin
                  state_next = ST_WAIT_RDY;
               end
            end
         end
         // The divider has no reset, so it may still be finishing an aborted op.
         ST_WAIT_RDY: if (div_ready) state_next = ST_ISSUE;
         ST_ISSUE:    state_next = ST_WAIT_DIV;
         ST_WAIT_DIV: begin
            if (div_valid) begin
               quo_next   = div_quo;
               rem_next   = div_rem;
               state_next = ST_FIX;
            end
         end
         ST_FIX: begin
            if (b_zero_reg) begin
               result_next = op_reg[1] ? rs1_reg : ALL_ONES;
            end else begin
               case (op_reg)
                  OP_DIV:  result_next = neg_if(neg_a_reg ^ neg_b_reg, quo_reg);
                  OP_REM:  result_next = neg_if(neg_a_reg, rem_reg);
                  OP_DIVU: result_next = quo_reg;
                  default: result_next = rem_reg;
               endcase
            end
            state_next = ST_DONE;
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   assign ready     = (state_reg == ST_IDLE);
   assign valid     = (state_reg == ST_DONE);
   assign div_start = (state_reg == ST_ISSUE);
   assign result    = result_reg;

endmodule

// File: tb/tb_div_signed_frontend.sv
// Scoreboard bench: drives both FAST_SPECIAL variants with the same operations;
// a monitor pops expected results whenever either instance pulses valid.
module tb_div_signed_frontend;
   import div_signed_frontend_pkg::*;

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          t;
      string       nm;
   } exp_t;

   logic              clk;
   logic              reset;
   logic              start;
   logic [1:0]        op;
   logic [31:0]       rs1;
   logic [31:0]       rs2;
   logic [1:0]        ready_w;
   logic [1:0]        valid_w;
   logic [1:0][31:0]  result_w;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   logic [1:0] prev_valid = 2'b00;
   exp_t q0[$];
   exp_t q1[$];

   div_signed_frontend #(.FAST_SPECIAL(1)) dut_fast (
      .clk(clk), .reset(reset), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
      .ready(ready_w[0]), .valid(valid_w[0]), .result(result_w[0])
   );

   div_signed_frontend #(.FAST_SPECIAL(0)) dut_slow (
      .clk(clk), .reset(reset), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
      .ready(ready_w[1]), .valid(valid_w[1]), .result(result_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic string tag(input int d);
      return (d == 0) ? "fast" : "slow";
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", nm, act, req);
      end
   endtask

   // Independent RISC-V reference for the random section.
   function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
      case (o)
         2'b00:   return 32'($signed(a) / $signed(b));
         2'b01:   return a / b;
         2'b10:   return 32'($signed(a) % $signed(b));
         default: return a % b;
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'h8000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'($urandom_range(0, 20));
         3:       return 32'd0 - 32'($urandom_range(1, 20));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic mon_step(input int d);
      exp_t e;
      logic v;
      int   have;
      v = valid_w[d];
      if (prev_valid[d]) chk($sformatf("%s valid_width", tag(d)), {31'd0, v}, 32'd0);
      if (v) begin
         have = (d == 0) ? q0.size() : q1.size();
         if (have == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s unexpected_valid: got valid with result %h, required no valid", tag(d), result_w[d]);
         end else begin
            if (d == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            $display("txn %s %s result=%h expected=%h at cycle %0d", tag(d), e.nm, result_w[d], e.res, cyc);
            chk($sformatf("%s %s result", tag(d), e.nm), result_w[d], e.res);
            if (e.lat >= 0) chk($sformatf("%s %s latency", tag(d), e.nm), 32'(cyc - e.t), 32'(e.lat));
         end
      end
      prev_valid[d] = v;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         mon_step(0);
         mon_step(1);
      end
   end

   // Waits for both instances to be ready, issues one op, queues expectations.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input int lat_f, input int lat_s, input string nm);
      exp_t e;
      int   w;
      w = 0;
      while (!(ready_w[0] && ready_w[1]) && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (w >= 300) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s ready_timeout: got ready=%b, required 11", nm, ready_w);
         return;
      end
      op = o; rs1 = a; rs2 = b; start = 1'b1;
      e.res = r; e.t = cyc; e.nm = nm;
      e.lat = lat_f; q0.push_back(e);
      e.lat = lat_s; q1.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk({nm, " ready_low"}, {30'd0, ready_w}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1);
   end

   initial begin
      int w;
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      reset = 1'b1; start = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s reset_ready", tag(d)), {31'd0, ready_w[d]}, 32'd1);
         chk($sformatf("%s reset_valid", tag(d)), {31'd0, valid_w[d]}, 32'd0);
         chk($sformatf("%s reset_result", tag(d)), result_w[d], 32'd0);
      end

      // Directed vectors: op, rs1, rs2, expected, latency fast/slow.
      issue(OP_DIV,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 37, 37, "div_7_m2");
      issue(OP_REM,  32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 37, 37, "rem_7_m2");
      issue(OP_REM,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 37, 37, "rem_m7_2");
      issue(OP_DIVU, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, 37, 37, "divu_max_2");
      issue(OP_REMU, 32'hFFFF_FFFF,  32'd2,         32'h0000_0001, 37, 37, "remu_max_2");
      issue(OP_DIV,  32'd5,          32'd0,         32'hFFFF_FFFF,  1, 37, "div_5_0");
      issue(OP_REM,  32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB,  1, 37, "rem_m5_0");
      issue(OP_REMU, 32'd9,          32'd0,         32'h0000_0009,  1, 37, "remu_9_0");
      issue(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000,  1, 37, "div_ovf");
      issue(OP_REM,  32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000,  1, 37, "rem_ovf");
      issue(OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000,  5,  5, "divu_min_max");
      issue(OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000,  5,  5, "remu_min_max");
      issue(OP_DIV,  32'd3,          32'd10,        32'h0000_0000,  5,  5, "div_3_10");
      issue(OP_REM,  32'd3,          32'd10,        32'h0000_0003,  5,  5, "rem_3_10");

      // Abort a long divide mid-flight; its result must never appear.
      issue(OP_DIVU, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, -1, -1, "divu_abort");
      repeat (10) @(negedge clk);
      reset = 1'b1;
      q0.delete();
      q1.delete();
      @(negedge clk);
      reset = 1'b0;
      chk("abort ready_after_reset", {30'd0, ready_w}, 32'd3);
      chk("abort valid_after_reset", {30'd0, valid_w}, 32'd0);
      issue(OP_DIV, 32'd100, 32'd7, 32'd14, -1, -1, "div_100_7");
      op = OP_DIVU; rs1 = 32'd1; rs2 = 32'd1; start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      chk("busy ready_still_low", {30'd0, ready_w}, 32'd0);

      // start coinciding with reset must not be accepted.
      w = 0;
      while (!(ready_w[0] && ready_w[1]) && w < 300) begin
         @(negedge clk);
         w++;
      end
      op = OP_DIV; rs1 = 32'd1; rs2 = 32'd0; start = 1'b1; reset = 1'b1;
      @(negedge clk);
      start = 1'b0; reset = 1'b0;
      chk("start_with_reset ready", {30'd0, ready_w}, 32'd3);
      chk("start_with_reset valid", {30'd0, valid_w}, 32'd0);

      for (int i = 0; i < 16; i++) begin
         ro = 2'($urandom_range(0, 3));
         ra = pick();
         rb = pick();
         issue(ro, ra, rb, ref_div(ro, ra, rb), -1, -1, $sformatf("rand%0d_op%0d_%h_%h", i, ro, ra, rb));
      end

      w = 0;
      while ((q0.size() != 0 || q1.size() != 0) && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (w >= 500) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d/%0d pending, required 0/0", q0.size(), q1.size());
      end
      repeat (40) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
